// File: rtl/fp_add_normalizer.sv
// fp_add_normalizer: post-add normalization stage of the single-precision adder.
// Takes the raw carry+mantissa sum, the pre-normalization exponent and sign,
// and the leading-zero count of mant_in[MAN_W:0]. It classifies the beat
// (Inf pass-through, carry, cancellation, underflow or normal), then shifts,
// adjusts the exponent, checks overflow and packs an IEEE-754 word.
// Two pipeline stages that advance in lockstep under a valid/ready handshake.
//
// Build option: define FPN_ROUND_EN for round-to-nearest-even on the carry
// path. When it is undefined, the guard bit is truncated.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  input handshake (in_ready is combinational)
//   sign_in, exp_in      sign and larger-operand exponent of the sum
//   mant_in              raw sum {carry, hidden, fraction}
//   zeros_in             leading zeros of mant_in[MAN_W:0] (MAN_W+1 = all zero)
//   out_valid / out_ready  output handshake
//   result               {sign, exp, frac}
//   flags                {ovf, uf, zero}
module fp_add_normalizer #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned ZW    = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   sign_in,
    input  logic [EXP_W-1:0]       exp_in,
    input  logic [MAN_W+1:0]       mant_in,
    input  logic [ZW-1:0]          zeros_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [2:0]             flags
);

    localparam int unsigned XW = EXP_W + 1;
    localparam int unsigned FW = MAN_W + 1;
    localparam logic [XW-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    typedef enum logic [2:0] {
        CL_N   = 3'd0,
        CL_C   = 3'd1,
        CL_Z   = 3'd2,
        CL_U   = 3'd3,
        CL_INF = 3'd4
    } cls_t;

    // Stage-1 registers
    logic              v1;
    logic              sign1;
    logic [XW-1:0]     exp1;
    logic [MAN_W:0]    mant1;
    logic [ZW-1:0]     zeros1;
    cls_t              cls1;

    // Stage-1 combinational classification
    cls_t              cls_c;
    logic [XW-1:0]     exp_adj_c;

    // Stage-2 combinational result
    logic              sign_c;
    logic [XW-1:0]     exp_c;
    logic [MAN_W-1:0]  frac_c;
    logic [FW-1:0]     rnd_c;
    logic              ovf_c;
    logic              uf_c;
    logic              zero_c;

    logic adv;

    // Both stages move together whenever the output register can be refilled
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Classification in priority order; exponent math one bit wider than EXP_W
    always_comb begin
        cls_c     = CL_N;
        exp_adj_c = XW'(exp_in) - XW'(zeros_in);
        if (exp_in == '1) begin
            cls_c     = CL_INF;
            exp_adj_c = EXP_MAX;
        end else if (mant_in[MAN_W+1]) begin
            cls_c     = CL_C;
            exp_adj_c = XW'(exp_in) + XW'(1);
        end else if (zeros_in == ZW'(MAN_W + 1)) begin
            cls_c     = CL_Z;
            exp_adj_c = '0;
        end else if (XW'(exp_in) <= XW'(zeros_in)) begin
            cls_c     = CL_U;
            exp_adj_c = '0;
        end
    end

    // Shift, optional rounding, overflow check and packing
    always_comb begin
        sign_c = sign1;
        exp_c  = '0;
        frac_c = '0;
        rnd_c  = '0;
        ovf_c  = 1'b0;
        uf_c   = 1'b0;
        zero_c = 1'b0;
        case (cls1)
            CL_C: begin
                // Right shift by one: mant1[0] is the guard bit
`ifdef FPN_ROUND_EN
                rnd_c = {1'b0, mant1[MAN_W:1]} + FW'(mant1[0] & mant1[1]);
`else
                rnd_c = {1'b0, mant1[MAN_W:1]};
`endif
                frac_c = rnd_c[MAN_W-1:0];
                exp_c  = exp1 + XW'(rnd_c[MAN_W]);
            end
            CL_N: begin
                // Hidden bit leaves the top of the field during the left shift
                frac_c = mant1[MAN_W-1:0] << zeros1;
                exp_c  = exp1;
            end
            CL_Z: begin
                sign_c = 1'b0;
                zero_c = 1'b1;
            end
            CL_U: begin
                uf_c = 1'b1;
            end
            CL_INF: begin
                exp_c = EXP_MAX;
            end
            default: begin
                exp_c = '0;
            end
        endcase
        if (exp_c >= EXP_MAX) begin
            ovf_c  = 1'b1;
            exp_c  = EXP_MAX;
            frac_c = '0;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            sign1     <= 1'b0;
            exp1      <= '0;
            mant1     <= '0;
            zeros1    <= '0;
            cls1      <= CL_N;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (adv) begin
            v1        <= in_valid;
            sign1     <= sign_in;
            exp1      <= exp_adj_c;
            mant1     <= mant_in[MAN_W:0];
            zeros1    <= zeros_in;
            cls1      <= cls_c;
            out_valid <= v1;
            if (v1) begin
                result <= {sign_c, exp_c[EXP_W-1:0], frac_c};
                flags  <= {ovf_c, uf_c, zero_c};
            end
        end
    end

endmodule
